// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: captures register writes (and, with TRACE_BRANCH_EN, taken
// branches) into a show-ahead FIFO drained over a valid/ready port.
module wb_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PC_W       = 10,
  parameter int DATA_W     = 8,
  localparam int ENTRY_W   = 2 + PC_W + 3 + DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_en,
  input  logic                  clear,
  input  logic [PC_W-1:0]       prog_ctr,
  input  logic [2:0]            destreg,
  input  logic [DATA_W-1:0]     reg_wr_data,
  input  logic                  reg_wr_enab,
  input  logic                  took_branch,
  input  logic                  memwb_inv_instr,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [ENTRY_W-1:0]    rd_entry,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_count;

  logic                  w_br;
  logic                  w_ev;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_entry;

`ifdef TRACE_BRANCH_EN
  assign w_br = took_branch;
`else
  assign w_br = 1'b0;
`endif

  assign w_ev   = trace_en & ~memwb_inv_instr & (reg_wr_enab | w_br);
  assign w_full = (r_count == FULL_CNT);
  // clear wins over both ports; its same-cycle event is not a drop
  assign w_pop  = (r_count != '0) & rd_ready & ~clear;
  assign w_push = w_ev & (~w_full | w_pop) & ~clear;
  assign w_drop = w_ev & w_full & ~w_pop & ~clear;

  // Entry packing; dest/data are zeroed for non-writing branch entries
  always_comb begin
    w_entry = '0;
    if (reg_wr_enab) begin
      w_entry = {w_br, 1'b1, prog_ctr, destreg, reg_wr_data};
    end else begin
      w_entry = {w_br, 1'b0, prog_ctr, 3'd0, {DATA_W{1'b0}}};
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy and drop status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  // Show-ahead head; forced to zero when empty so reset presents a clean entry
  always_comb begin
    if (r_count != '0) begin
      rd_entry = r_mem[r_rd_ptr];
    end else begin
      rd_entry = '0;
    end
  end

  assign rd_valid   = (r_count != '0);
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed vector table plus overflow,
// full+pop, saturation and asynchronous-reset sequences.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, clear, reg_wr_enab, took_branch, memwb_inv_instr, rd_ready;
  logic [9:0]  prog_ctr;
  logic [2:0]  destreg;
  logic [7:0]  reg_wr_data;
  logic        rd_valid;
  logic [22:0] rd_entry;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_trace_buffer dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .prog_ctr(prog_ctr), .destreg(destreg), .reg_wr_data(reg_wr_data),
    .reg_wr_enab(reg_wr_enab), .took_branch(took_branch),
    .memwb_inv_instr(memwb_inv_instr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_entry(rd_entry), .count(count),
    .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic        te, inv, wr, br, rdy, clr;
    logic [9:0]  pc;
    logic [2:0]  dest;
    logic [7:0]  data;
    logic [4:0]  e_count;
    logic        e_valid;
    logic [22:0] e_entry;
    logic        e_ovf;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_status(input string tag, input logic [4:0] c, input logic v,
                              input logic o, input logic [7:0] d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
    check({tag, ".overflow"}, 32'(overflow), 32'(o));
    check({tag, ".drop_count"}, 32'(drop_count), 32'(d));
  endtask

  task automatic cyc(input logic te, input logic inv, input logic wr, input logic br,
                     input logic [9:0] pc, input logic [2:0] dest, input logic [7:0] data,
                     input logic rdy, input logic clr);
    trace_en = te; memwb_inv_instr = inv; reg_wr_enab = wr; took_branch = br;
    prog_ctr = pc; destreg = dest; reg_wr_data = data; rd_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
    trace_en = 1'b0; reg_wr_enab = 1'b0; took_branch = 1'b0; rd_ready = 1'b0;
    clear = 1'b0; memwb_inv_instr = 1'b0;
  endtask

  task automatic wr_cyc(input logic [9:0] pc, input logic [7:0] data, input logic rdy);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, pc, 3'd1, data, rdy, 1'b0);
  endtask

  task automatic pop_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 8'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // te inv wr br rdy clr pc dest data | count valid entry ovf drop
    vecs[0] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10'h005,3'd3,8'hA5,
                5'd1,1'b1,{1'b0,1'b1,10'h005,3'd3,8'hA5},1'b0,8'd0};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,10'h006,3'd0,8'h00,
                5'd0,1'b0,23'd0,1'b0,8'd0};
    vecs[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,10'h007,3'd2,8'h11,
                5'd0,1'b0,23'd0,1'b0,8'd0};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,10'h008,3'd2,8'h22,
                5'd0,1'b0,23'd0,1'b0,8'd0};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,10'h3FF,3'd7,8'hFF,
                5'd1,1'b1,{1'b0,1'b1,10'h3FF,3'd7,8'hFF},1'b0,8'd0};
`ifdef TRACE_BRANCH_EN
    vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,10'h040,3'd5,8'h77,
                5'd2,1'b1,{1'b0,1'b1,10'h3FF,3'd7,8'hFF},1'b0,8'd0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,10'h000,3'd0,8'h00,
                5'd1,1'b1,{1'b1,1'b0,10'h040,3'd0,8'h00},1'b0,8'd0};
    vecs[7] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,10'h041,3'd2,8'h3C,
                5'd1,1'b1,{1'b1,1'b1,10'h041,3'd2,8'h3C},1'b0,8'd0};
`else
    vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,10'h040,3'd5,8'h77,
                5'd1,1'b1,{1'b0,1'b1,10'h3FF,3'd7,8'hFF},1'b0,8'd0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,10'h000,3'd0,8'h00,
                5'd0,1'b0,23'd0,1'b0,8'd0};
    vecs[7] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,10'h041,3'd2,8'h3C,
                5'd1,1'b1,{1'b0,1'b1,10'h041,3'd2,8'h3C},1'b0,8'd0};
`endif
    vecs[8] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,10'h000,3'd0,8'h00,
                5'd0,1'b0,23'd0,1'b0,8'd0};
    vecs[9] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,10'h050,3'd4,8'h99,
                5'd0,1'b0,23'd0,1'b0,8'd0};

    trace_en = 1'b0; clear = 1'b0; reg_wr_enab = 1'b0; took_branch = 1'b0;
    memwb_inv_instr = 1'b0; rd_ready = 1'b0; prog_ctr = 10'd0; destreg = 3'd0;
    reg_wr_data = 8'd0;
    reset = 1'b1;
    #12;
    check_status("reset", 5'd0, 1'b0, 1'b0, 8'd0);
    check("reset.rd_entry", 32'(rd_entry), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].te, vecs[i].inv, vecs[i].wr, vecs[i].br, vecs[i].pc, vecs[i].dest,
          vecs[i].data, vecs[i].rdy, vecs[i].clr);
      check_status($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_valid,
                   vecs[i].e_ovf, vecs[i].e_drop);
      check($sformatf("vec%0d.rd_entry", i), 32'(rd_entry), 32'(vecs[i].e_entry));
    end

    // overflow: 20 writes into an idle-consumer FIFO keep the first 16
    for (int i = 0; i < 20; i++) wr_cyc(10'(i), 8'(i), 1'b0);
    check_status("ovf.full", 5'd16, 1'b1, 1'b1, 8'd4);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf.drain%0d", i), 32'(rd_entry),
            32'({1'b0, 1'b1, 10'(i), 3'd1, 8'(i)}));
      pop_cyc();
    end
    check_status("ovf.drained", 5'd0, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 8'd0, 1'b0, 1'b1);
    check_status("ovf.clear", 5'd0, 1'b0, 1'b0, 8'd0);

    // offset the pointers so the full+pop sequence wraps mid-array
    for (int i = 0; i < 5; i++) wr_cyc(10'h100, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) pop_cyc();
    for (int i = 0; i < 16; i++) wr_cyc(10'(10'h200 + i), 8'(8'h40 + i), 1'b0);
    check_status("fp.full", 5'd16, 1'b1, 1'b0, 8'd0);
    wr_cyc(10'h2EE, 8'hEE, 1'b1);
    check_status("fp.pushpop", 5'd16, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fp.drain%0d", i), 32'(rd_entry),
            32'({1'b0, 1'b1, 10'(10'h200 + i), 3'd1, 8'(8'h40 + i)}));
      pop_cyc();
    end
    check("fp.last", 32'(rd_entry), 32'({1'b0, 1'b1, 10'h2EE, 3'd1, 8'hEE}));
    pop_cyc();
    check_status("fp.empty", 5'd0, 1'b0, 1'b0, 8'd0);

    // drop counter saturates at 255
    for (int i = 0; i < 16 + 260; i++) wr_cyc(10'(i), 8'(i), 1'b0);
    check_status("sat", 5'd16, 1'b1, 1'b1, 8'd255);
    for (int i = 0; i < 13; i++) pop_cyc();
    check_status("sat.three", 5'd3, 1'b1, 1'b1, 8'd255);

    // asynchronous reset with three entries queued
    #2;
    reset = 1'b1;
    #1;
    check_status("areset", 5'd0, 1'b0, 1'b0, 8'd0);
    check("areset.rd_entry", 32'(rd_entry), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    wr_cyc(10'h123, 8'h5A, 1'b0);
    check("post_reset.rd_entry", 32'(rd_entry), 32'({1'b0, 1'b1, 10'h123, 3'd1, 8'h5A}));
    check_status("post_reset", 5'd1, 1'b1, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
